// File: rtl/alu_sequencer.sv
// Fetch/decode/writeback controller: owns the PC and architectural flags, decodes the
// instruction register into ALU control fields, and writes ALU results back to the register file.
module alu_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  output logic [7:0]  o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_data,
  output logic [3:0]  o_Cond,
  output logic [3:0]  o_OP,
  output logic        o_S,
  output logic        o_instc,
  output logic [2:0]  o_SRcon,
  output logic [4:0]  o_shiftamt,
  output logic [15:0] o_imval,
  output logic [2:0]  o_rn_addr,
  output logic [2:0]  o_rm_addr,
  input  logic [31:0] i_result,
  input  logic [3:0]  i_flags,
  output logic        o_rf_we,
  output logic [2:0]  o_rd_addr,
  output logic [31:0] o_rf_wdata,
  output logic [3:0]  o_flags,
  output logic [7:0]  o_pc,
  output logic        o_halted,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;
  logic        cond_pass;
  logic        f_n, f_z, f_c, f_v;

  // Instruction fetch handshake: o_imem_req is held high for the whole FETCH state; the
  // word on i_imem_data is taken on the first rising edge where i_imem_valid is also high.
  // i_imem_valid is ignored in every other state.

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  // Field decode is purely from IR, so it holds steady from DECODE through WRITEBACK.
  assign o_Cond     = ir_q[31:28];
  assign o_OP       = ir_q[27:24];
  assign o_S        = ir_q[23];
  assign o_instc    = ir_q[22];
  assign o_SRcon    = ir_q[21:19];
  assign o_rd_addr  = ir_q[18:16];
  assign o_rn_addr  = ir_q[15:13];
  assign o_rm_addr  = ir_q[22] ? 3'd0 : ir_q[12:10];
  assign o_shiftamt = ir_q[22] ? 5'd0 : ir_q[9:5];
  assign o_imval    = ir_q[22] ? {4'd0, ir_q[11:0]} : 16'd0;

  assign o_imem_addr = pc_q;
  assign o_pc        = pc_q;
  assign o_flags     = flags_q;
  assign o_halted    = (state_q == S_HALT);
  assign o_dbg_state = state_q;

  assign {f_n, f_z, f_c, f_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (ir_q[31:28])
      4'b0000: cond_pass = 1'b1;
      4'b0001: cond_pass = f_z;
      4'b0010: cond_pass = !f_z && (f_n == f_v);
      4'b0011: cond_pass = (f_n != f_v);
      4'b0100: cond_pass = f_c;
      4'b0101: cond_pass = f_n;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    flags_d    = flags_q;
    o_imem_req = 1'b0;
    o_rf_we    = 1'b0;
    o_rf_wdata = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_valid) begin
          ir_d    = i_imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = (ir_q == 32'hFFFF_FFFF) ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 8'd1;
        if (cond_pass) begin
          // OP 0..7 write a register; compare (8) and branch (15) never do.
          if (!ir_q[27]) begin
            o_rf_we    = 1'b1;
            o_rf_wdata = i_result;
          end
          if (ir_q[27:24] == 4'hF) pc_d = ir_q[7:0];
          if (ir_q[23]) flags_d = i_flags;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
